// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit interval timer with an 8-bit prescaler.
// It responds to an 8-byte window at BASE_ADDR and drives a level IRQ.
// Optional macro BUS_TIMER_CAPTURE_EN: a CNT_LO read stores counter[15:8]
// in a shadow register. A later CNT_HI read returns that shadow value, so a
// LO-then-HI read pair gives a coherent 16-bit count.
module bus_timer #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  wr_data,
  input  logic        wr_enable,
  output logic [7:0]  rd_data,
  output logic        sel,
  output logic        irq
);

  localparam logic [2:0] OFF_CNT_LO   = 3'd0;
  localparam logic [2:0] OFF_CNT_HI   = 3'd1;
  localparam logic [2:0] OFF_CTRL     = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  logic [15:0] latch_q, latch_d;
  logic [15:0] counter_q, counter_d;
  logic        run_q, run_d;
  logic        cont_q, cont_d;
  logic        irqEn_q, irqEn_d;
  logic        expired_q, expired_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  preCnt_q, preCnt_d;
  logic        irq_q, irq_d;
`ifdef BUS_TIMER_CAPTURE_EN
  logic [7:0]  shadow_q, shadow_d;
`endif

  logic [2:0] offset;
  logic       wrEn;
  logic       rdEn;
  logic       tick;
  logic       preLoad;
  logic       statusClear;

  // Address decode, bus strobes and the prescaler tick.
  always_comb begin
    sel         = (address[15:3] == BASE_ADDR[15:3]);
    offset      = address[2:0];
    wrEn        = sel & wr_enable;
    rdEn        = sel & ~wr_enable;
    tick        = run_q & (preCnt_q == 8'd0);
    preLoad     = (wrEn && (offset == OFF_CNT_HI)) ||
                  (wrEn && (offset == OFF_CTRL) && wr_data[0] && !run_q);
    statusClear = (rdEn && (offset == OFF_STATUS)) ||
                  (wrEn && (offset == OFF_STATUS) && wr_data[0]);
  end

  // Next state: apply the countdown first, then let bus writes override it.
  always_comb begin
    latch_d    = latch_q;
    counter_d  = counter_q;
    run_d      = run_q;
    cont_d     = cont_q;
    irqEn_d    = irqEn_q;
    expired_d  = expired_q;
    prescale_d = prescale_q;
    preCnt_d   = preCnt_q;
`ifdef BUS_TIMER_CAPTURE_EN
    shadow_d   = shadow_q;
    if (rdEn && (offset == OFF_CNT_LO)) shadow_d = counter_q[15:8];
`endif

    if (statusClear) expired_d = 1'b0;

    if (tick) begin
      if (counter_q != 16'd0) begin
        counter_d = counter_q - 16'd1;
      end else begin
        expired_d = 1'b1;
        if (cont_q) counter_d = latch_q;
        else        run_d     = 1'b0;
      end
    end

    if (preLoad)     preCnt_d = prescale_q;
    else if (run_q)  preCnt_d = (preCnt_q == 8'd0) ? prescale_q : preCnt_q - 8'd1;

    if (wrEn) begin
      case (offset)
        OFF_CNT_LO: latch_d[7:0] = wr_data;
        OFF_CNT_HI: begin
          latch_d[15:8] = wr_data;
          counter_d     = {wr_data, latch_q[7:0]};
        end
        OFF_CTRL: begin
          run_d   = wr_data[0];
          cont_d  = wr_data[1];
          irqEn_d = wr_data[2];
        end
        OFF_PRESCALE: prescale_d = wr_data;
        default: ;
      endcase
    end

    irq_d = expired_d & irqEn_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      latch_q    <= RESET_LATCH;
      counter_q  <= RESET_LATCH;
      run_q      <= 1'b0;
      cont_q     <= 1'b0;
      irqEn_q    <= 1'b0;
      expired_q  <= 1'b0;
      prescale_q <= 8'd0;
      preCnt_q   <= 8'd0;
      irq_q      <= 1'b0;
`ifdef BUS_TIMER_CAPTURE_EN
      shadow_q   <= 8'd0;
`endif
    end else begin
      latch_q    <= latch_d;
      counter_q  <= counter_d;
      run_q      <= run_d;
      cont_q     <= cont_d;
      irqEn_q    <= irqEn_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      preCnt_q   <= preCnt_d;
      irq_q      <= irq_d;
`ifdef BUS_TIMER_CAPTURE_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  // Combinational read mux; returns zero outside the window so it can be ORed.
  always_comb begin
    rd_data = 8'h00;
    if (sel) begin
      case (offset)
        OFF_CNT_LO:   rd_data = counter_q[7:0];
`ifdef BUS_TIMER_CAPTURE_EN
        OFF_CNT_HI:   rd_data = shadow_q;
`else
        OFF_CNT_HI:   rd_data = counter_q[15:8];
`endif
        OFF_CTRL:     rd_data = {5'b00000, irqEn_q, cont_q, run_q};
        OFF_STATUS:   rd_data = {7'b0000000, expired_q};
        OFF_PRESCALE: rd_data = prescale_q;
        default:      rd_data = 8'h00;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: self-checking bench for bus_timer.
// A table covers reset readback and address decode. Hand-written sequences
// cover one-shot, continuous mode, the read/expiry collision, capture, and
// reset in the middle of a count. Expected values go into a queue and are
// popped when the DUT output is sampled.
module tb_bus_timer;

  localparam logic [15:0] BASE = 16'hD000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;
  logic [7:0]  rd_data;
  logic        sel;
  logic        irq;

  int edgeCount = 0;
  int nChecks = 0;
  int nFails = 0;

  typedef struct {
    string      name;
    logic [7:0] value;
  } expT;

  expT expQ[$];

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        expSel;
    logic        chkRd;
    logic [7:0]  expRd;
  } vecT;

  vecT vecs[16];

  bus_timer #(.BASE_ADDR(16'hD000), .RESET_LATCH(16'hFFFF)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .address   (address),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .rd_data   (rd_data),
    .sel       (sel),
    .irq       (irq)
  );

  // Free-running clock for the DUT.
  always #5 clk = ~clk;

  // Counts rising edges so the bench can place events at exact cycles.
  always @(posedge clk) edgeCount++;

  // Stops a hung run so that the run still reports an error.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectVal(input string name, input logic [7:0] value);
    expT e;
    e.name  = name;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [7:0] actual);
    expT e;
    nChecks++;
    if (expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_empty: got %h, expected a queued value", actual);
    end else begin
      e = expQ.pop_front();
      if (actual !== e.value) begin
        nFails++;
        $display("[TB] FAIL %s: got %h, expected %h", e.name, actual, e.value);
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] data);
    @(negedge clk);
    address   = addr;
    wr_enable = we;
    wr_data   = data;
    #1;
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
    address   = 16'h0000;
    wr_enable = 1'b0;
    wr_data   = 8'h00;
  endtask

  task automatic writeReg(input logic [2:0] off, input logic [7:0] data);
    applyStimulus(BASE | {13'd0, off}, 1'b1, data);
    endCycle();
  endtask

  task automatic readReg(input logic [2:0] off, input logic [7:0] exp, input string name);
    applyStimulus(BASE | {13'd0, off}, 1'b0, 8'h00);
    expectVal(name, exp);
    checkOutput(rd_data);
    endCycle();
  endtask

  task automatic checkIrq(input string name, input logic exp);
    expectVal(name, {7'b0000000, exp});
    checkOutput({7'b0000000, irq});
  endtask

  task automatic waitEdge(input int t);
    int guard = 0;
    while (edgeCount < t && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edgeCount != t) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL wait_edge: got edge %0d, expected edge %0d", edgeCount, t);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn    = 1'b0;
    address   = 16'h0000;
    wr_enable = 1'b0;
    wr_data   = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Main test sequence.
  initial begin
    int e0;
    int target;
    logic [7:0] capHiExp;

    resetn    = 1'b0;
    address   = 16'h0000;
    wr_enable = 1'b0;
    wr_data   = 8'h00;

    vecs[0]  = '{16'hD000, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF};
    vecs[1]  = '{16'hD001, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF};
    vecs[2]  = '{16'hD002, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[3]  = '{16'hD003, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[4]  = '{16'hD004, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[5]  = '{16'hD005, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[6]  = '{16'hD006, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[7]  = '{16'hD007, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[8]  = '{16'hD008, 1'b1, 8'h07, 1'b0, 1'b1, 8'h00};
    vecs[9]  = '{16'hCFFF, 1'b1, 8'h07, 1'b0, 1'b1, 8'h00};
    vecs[10] = '{16'hD00A, 1'b1, 8'h07, 1'b0, 1'b1, 8'h00};
    vecs[11] = '{16'hCFFC, 1'b1, 8'h09, 1'b0, 1'b1, 8'h00};
    vecs[12] = '{16'hD005, 1'b1, 8'h07, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{16'hD002, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[14] = '{16'hD004, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[15] = '{16'hD000, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF};

    doReset();
    @(posedge clk);
    #1;
    checkIrq("reset_irq", 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      expectVal($sformatf("vec%0d_sel", i), {7'b0000000, vecs[i].expSel});
      checkOutput({7'b0000000, sel});
      if (vecs[i].chkRd) begin
        expectVal($sformatf("vec%0d_rd", i), vecs[i].expRd);
        checkOutput(rd_data);
      end
      endCycle();
    end
    readReg(3'd1, 8'hFF, "decode_cnt_hi");
    checkIrq("decode_irq", 1'b0);

    $display("[TB] one-shot, prescale 0");
    writeReg(3'd4, 8'h00);
    writeReg(3'd0, 8'h03);
    writeReg(3'd1, 8'h00);
    writeReg(3'd2, 8'h05);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      checkIrq($sformatf("oneshot_irq_t%0d", i), (i == 4));
    end
    readReg(3'd2, 8'h04, "oneshot_ctrl");
    readReg(3'd0, 8'h00, "oneshot_cnt_lo");
    readReg(3'd1, 8'h00, "oneshot_cnt_hi");
    checkIrq("oneshot_irq_held", 1'b1);
    readReg(3'd3, 8'h01, "oneshot_status");
    checkIrq("oneshot_irq_cleared", 1'b0);
    readReg(3'd3, 8'h00, "oneshot_status_after");

    $display("[TB] continuous, prescale 3");
    writeReg(3'd4, 8'h03);
    writeReg(3'd0, 8'h01);
    writeReg(3'd1, 8'h00);
    writeReg(3'd2, 8'h07);
    e0 = edgeCount;
    for (int k = 1; k <= 3; k++) begin
      target = e0 + 8 * k;
      waitEdge(target - 1);
      checkIrq($sformatf("cont_pre_%0d", k), 1'b0);
      waitEdge(target);
      checkIrq($sformatf("cont_expire_%0d", k), 1'b1);
      writeReg(3'd3, 8'h01);
      checkIrq($sformatf("cont_clear_%0d", k), 1'b0);
    end

    $display("[TB] status read colliding with expiry");
    target = e0 + 32;
    waitEdge(target - 1);
    readReg(3'd3, 8'h00, "collision_rd");
    checkIrq("collision_irq", 1'b1);
    readReg(3'd3, 8'h01, "collision_status");
    checkIrq("collision_irq_cleared", 1'b0);
    readReg(3'd0, 8'h01, "reload_cnt_lo");
    readReg(3'd1, 8'h00, "reload_cnt_hi");
    writeReg(3'd2, 8'h00);

    $display("[TB] capture sequence");
`ifdef BUS_TIMER_CAPTURE_EN
    capHiExp = 8'h01;
`else
    capHiExp = 8'h00;
`endif
    writeReg(3'd4, 8'h00);
    writeReg(3'd0, 8'h00);
    writeReg(3'd1, 8'h01);
    writeReg(3'd2, 8'h01);
    readReg(3'd0, 8'h00, "cap_lo");
    readReg(3'd1, capHiExp, "cap_hi");
    readReg(3'd0, 8'hFE, "cap_lo_live");

    $display("[TB] reset mid-count");
    doReset();
    @(posedge clk);
    #1;
    checkIrq("midreset_irq", 1'b0);
    readReg(3'd0, 8'hFF, "midreset_cnt_lo");
    readReg(3'd1, 8'hFF, "midreset_cnt_hi");
    readReg(3'd2, 8'h00, "midreset_ctrl");
    readReg(3'd3, 8'h00, "midreset_status");
    readReg(3'd4, 8'h00, "midreset_prescale");
    readReg(3'd0, 8'hFF, "midreset_frozen");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 16-bit programmable interval timer that sits as a responder on the processor's memory bus (address, wr_data, wr_enable, rd_data).
- Sits alongside memory_block in the address map; the top-level read mux ORs its rd_data with memory's.
- Provides a periodic or one-shot countdown with a prescaler and a level IRQ toward the processor, used for tick interrupts in test ROMs.

Parameters:
- BASE_ADDR, 16'hD000, base of the 8-byte register window; bits [2:0] must be zero.
- RESET_LATCH, 16'hFFFF, reset value of the reload latch and the counter.

Ports:
- clk  input  1  processor clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  input  16  processor bus address.
- wr_data  input  8  processor write data.
- wr_enable  input  1  processor write strobe; high means write this cycle.
- rd_data  output  8  combinational read data; 8'h00 when not selected.
- sel  output  1  combinational; high when address[15:3] == BASE_ADDR[15:3].
- irq  output  1  registered level interrupt; equals STATUS.expired AND CTRL.irq_en.

Behaviour:
- Register map (offset = address[2:0]):
  - 0 CNT_LO: read returns counter[7:0]; write sets latch[7:0].
  - 1 CNT_HI: read returns counter[15:8]; write sets latch[15:8], loads counter <= {wr_data, latch[7:0]}, and reloads the prescaler.
  - 2 CTRL: bit0 run, bit1 continuous (1 = reload, 0 = one-shot), bit2 irq_en; bits 7:3 read 0.
  - 3 STATUS: bit0 expired. A read clears it. A write with wr_data[0]=1 clears it; other write bits are ignored.
  - 4 PRESCALE: 8-bit divisor, read/write.
  - 5–7: read 8'h00; writes are ignored.
- Read vs write cycle:
  - A cycle with sel=1 and wr_enable=0 is a read. rd_data is valid combinationally in the same cycle.
  - Read side effects (STATUS clear, capture) take effect at the rising edge that ends the cycle.
  - A cycle with sel=1 and wr_enable=1 is a write, committed at that edge. It has no read side effects.
- Reset values:
  - latch and counter = RESET_LATCH; CTRL = 0; STATUS = 0; PRESCALE = 0; prescaler count = 0.
  - irq = 0; capture shadow = 0.
  - Reset mid-count aborts immediately; there is no pending expiry.
- Prescaler and tick:
  - The prescaler count reloads from PRESCALE on a CNT_HI write, or on a CTRL write that sets run from 0 to 1.
  - While run=1, the prescaler decrements each clock. When it is 0, a tick is asserted and the prescaler reloads.
  - Tick period is PRESCALE+1 clocks.
- Counter on a tick:
  - If counter != 0: counter decrements.
  - If counter == 0: expired <= 1.
    - Continuous mode: counter <= latch.
    - One-shot mode: run <= 0 and counter holds at 0.
  - Resulting period is (latch+1)*(PRESCALE+1) clocks.
- run=0: counter and prescaler freeze. Reads still return live values.
- irq: registered, updated every edge from the next-state expired and irq_en. It therefore deasserts the cycle after a clearing read or write.
- Simultaneous events:
  - Expiry in the same cycle as a STATUS read or clear-write: set wins, expired stays 1.
  - Expiry in the same cycle as a CNT_HI write: the write load wins; expired is still set.
  - Expiry in one-shot mode in the same cycle as a CTRL write: the CTRL write value wins for run.
  - Counter wrap-around never occurs; the counter never decrements below 0.

Optional Feature:
- Macro: BUS_TIMER_CAPTURE_EN.
- When defined:
  - A read of CNT_LO captures counter[15:8] into an 8-bit shadow at the end of that read cycle.
  - A read of CNT_HI returns the shadow, giving a coherent 16-bit read when read LO then HI.
- When not defined: CNT_HI reads return live counter[15:8] and no shadow register exists.

Test Plan:
- Reset: hold resetn low for 2 clocks, then read all 8 offsets -> 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00; irq=0.
- One-shot, prescale 0: write PRESCALE=0, CNT_LO=03, CNT_HI=00, CTRL=05 -> expired=1 and irq=1 exactly 4 ticks after the CTRL write. CTRL reads 8'h04 (run cleared) and the counter holds 0000. Reading STATUS returns 8'h01, and irq=0 the next cycle.
- Continuous, prescale 3: latch=0x0001, CTRL=07 -> expired sets every 8 clocks. Clear-writes of STATUS=01 between expiries drop irq each time.
- Decode: address D008 or CFFF with wr_enable=1 -> sel=0, rd_data=00, and no register changes. A write to D005 -> no effect.
- Collision: issue a STATUS read on the exact expiry cycle -> rd_data returns the pre-edge value, and expired stays 1 afterwards.
- Capture (macro defined): counter=0x0100 running with prescale 0. Read CNT_LO (00), then read CNT_HI one cycle later -> returns 8'h01 although the live counter is now 0x00FF. Without the macro the same sequence returns 8'h00.
